// File: rtl/regfile_mp_if.sv
// Register file access bundle: read ports (decode side) plus general and link write ports (writeback side).
// Parameters must match the regfile_mp instance that this bundle is attached to.
// master = requester driving addresses/writes, slave = the register file itself.
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_valid;

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH/8-1:0]      wr_be;
  logic [WIDTH-1:0]        wr_data;

  logic                    link_en;
  logic [WIDTH-1:0]        link_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, link_en, link_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, link_en, link_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled write port and link-register write port.
// Latency: reads are registered, data/valid appear one cycle after rd_en is sampled.
// Backpressure: none; every read and write is accepted on the cycle it is presented.
module regfile_mp #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int LINK_ADDR = 31,
  parameter int BYPASS    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  rf
);
  localparam int AW    = $clog2(DEPTH);
  localparam int NBYTE = WIDTH / 8;
  localparam logic [AW-1:0] LINK_IDX = AW'(LINK_ADDR);
  // A link register that aliases the zero register can never be written.
  localparam bit LINK_LIVE = !((ZERO_REG != 0) && (LINK_ADDR == 0));

  logic [WIDTH-1:0]             regs [DEPTH];
  logic [NUM_RD-1:0][WIDTH-1:0] res;
  logic [NUM_RD-1:0][WIDTH-1:0] data_q;
  logic [NUM_RD-1:0]            valid_q;
  logic                         wr_live;
  logic                         link_live;
  logic [AW-1:0]                ra;
  logic [WIDTH-1:0]             rv;

  // Qualify both write ports against the hardwired-zero register.
  always_comb begin
    wr_live   = rf.wr_en && !((ZERO_REG != 0) && (rf.wr_addr == '0));
    link_live = rf.link_en && LINK_LIVE;
  end

  // Storage update: byte-merged general write first, link write overrides on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_live) begin
        for (int b = 0; b < NBYTE; b++) begin
          if (rf.wr_be[b]) regs[rf.wr_addr][b*8 +: 8] <= rf.wr_data[b*8 +: 8];
        end
      end
      if (link_live) regs[LINK_IDX] <= rf.link_data;
    end
  end

  // Resolve each read address, optionally forwarding this cycle's writes.
  always_comb begin
    res = '0;
    ra  = '0;
    rv  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = rf.rd_addr[p*AW +: AW];
      rv = regs[ra];
      if (BYPASS != 0) begin
        if (wr_live && (rf.wr_addr == ra)) begin
          for (int b = 0; b < NBYTE; b++) begin
            if (rf.wr_be[b]) rv[b*8 +: 8] = rf.wr_data[b*8 +: 8];
          end
        end
        if (link_live && (LINK_IDX == ra)) rv = rf.link_data;
      end
      if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
      res[p] = rv;
    end
  end

  // Read output registers: data loads only on enable, valid tracks the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= rf.rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rf.rd_en[p]) data_q[p] <= res[p];
      end
    end
  end

  assign rf.rd_data  = data_q;
  assign rf.rd_valid = valid_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-port write-first instance and a 2-port read-old instance share one stimulus.
// An array model of the register contents predicts every output each cycle; literal checks pin the model.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   rd_en     = '0;
  logic [19:0]  rd_addr   = '0;
  logic         wr_en     = 1'b0;
  logic [4:0]   wr_addr   = '0;
  logic [3:0]   wr_be     = '0;
  logic [31:0]  wr_data   = '0;
  logic         link_en   = 1'b0;
  logic [31:0]  link_data = '0;

  regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(4)) ia ();
  regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) ib ();

  assign ia.rd_en = rd_en;          assign ib.rd_en = rd_en[1:0];
  assign ia.rd_addr = rd_addr;      assign ib.rd_addr = rd_addr[9:0];
  assign ia.wr_en = wr_en;          assign ib.wr_en = wr_en;
  assign ia.wr_addr = wr_addr;      assign ib.wr_addr = wr_addr;
  assign ia.wr_be = wr_be;          assign ib.wr_be = wr_be;
  assign ia.wr_data = wr_data;      assign ib.wr_data = wr_data;
  assign ia.link_en = link_en;      assign ib.link_en = link_en;
  assign ia.link_data = link_data;  assign ib.link_data = link_data;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(4), .ZERO_REG(1), .LINK_ADDR(31), .BYPASS(1))
    u_a (.clk(clk), .rst_n(rst_n), .rf(ia.slave));
  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .LINK_ADDR(31), .BYPASS(0))
    u_b (.clk(clk), .rst_n(rst_n), .rf(ib.slave));

  int vectors = 0;
  int miscompares = 0;

  // Model: register contents before and after each edge's writes.
  logic [31:0]  mem  [32];
  logic [31:0]  post [32];
  logic [127:0] exp_a_data  = '0;
  logic [3:0]   exp_a_valid = '0;
  logic [63:0]  exp_b_data  = '0;
  logic [1:0]   exp_b_valid = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      exp_a_data = '0; exp_a_valid = '0;
      exp_b_data = '0; exp_b_valid = '0;
    end else begin
      post = mem;
      if (wr_en && wr_addr != 5'd0)
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) post[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      if (link_en) post[31] = link_data;
      for (int p = 0; p < 4; p++) begin
        exp_a_valid[p] = rd_en[p];
        if (rd_en[p]) exp_a_data[32*p +: 32] = post[rd_addr[5*p +: 5]];
      end
      for (int p = 0; p < 2; p++) begin
        exp_b_valid[p] = rd_en[p];
        if (rd_en[p]) exp_b_data[32*p +: 32] = mem[rd_addr[5*p +: 5]];
      end
      mem = post;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    vectors++;
    if (ia.rd_data !== exp_a_data || ia.rd_valid !== exp_a_valid) begin
      miscompares++;
      $display("FAIL cycle_a t=%0t data=%h valid=%b required data=%h valid=%b",
               $time, ia.rd_data, ia.rd_valid, exp_a_data, exp_a_valid);
    end
    vectors++;
    if (ib.rd_data !== exp_b_data || ib.rd_valid !== exp_b_valid) begin
      miscompares++;
      $display("FAIL cycle_b t=%0t data=%h valid=%b required data=%h valid=%b",
               $time, ib.rd_data, ib.rd_valid, exp_b_data, exp_b_valid);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wr_en = 1'b0; wr_be = '0; link_en = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
  endtask

  task automatic rd0(input logic [4:0] a);
    rd_en = 4'b0001; rd_addr = {15'd0, a};
  endtask

  initial begin
    // Reset with a write and a read presented: nothing may land.
    wr(5'd5, 4'hF, 32'hFFFF_FFFF);
    rd0(5'd5);
    step(); step();
    chk("rst_data_a", ia.rd_data, 128'd0);
    chk("rst_valid_a", {124'd0, ia.rd_valid}, 128'd0);
    chk("rst_data_b", {64'd0, ib.rd_data}, 128'd0);
    rst_n = 1'b1;
    wr_en = 1'b0;
    step();
    chk("r5_after_rst", ia.rd_data[31:0], 128'd0);
    chk("r5_valid", {124'd0, ia.rd_valid}, 128'd1);

    // Byte enables.
    idle(); wr(5'd3, 4'b1111, 32'h1122_3344); step();
    wr(5'd3, 4'b0101, 32'hAABB_CCDD); step();
    idle(); wr(5'd3, 4'b0000, 32'hFFFF_FFFF); step();
    idle(); rd0(5'd3); step();
    chk("be_merge_a", ia.rd_data[31:0], 128'h11BB_33DD);
    chk("be_merge_b", ib.rd_data[31:0], 128'h11BB_33DD);

    // Zero register, same-cycle read under forwarding.
    idle(); wr(5'd0, 4'hF, 32'hDEAD_BEEF); rd0(5'd0); step();
    chk("r0_bypass", ia.rd_data[31:0], 128'd0);
    idle(); rd0(5'd0); step();
    chk("r0_read", ia.rd_data[31:0], 128'd0);

    // Link write collides with general write to r31.
    idle(); wr(5'd31, 4'hF, 32'h1); link_en = 1'b1; link_data = 32'h0040_0008; step();
    idle(); rd_en = 4'b0010; rd_addr = {10'd0, 5'd31, 5'd0}; step();
    chk("link_win_a", ia.rd_data[63:32], 128'h0040_0008);
    chk("link_win_b", ib.rd_data[63:32], 128'h0040_0008);

    // Forwarding vs read-old on the same stimulus.
    idle(); wr(5'd7, 4'hF, 32'h9); step();
    idle(); wr(5'd7, 4'hF, 32'h55); rd0(5'd7); step();
    chk("bypass1", ia.rd_data[31:0], 128'h55);
    chk("bypass0", ib.rd_data[31:0], 128'h9);
    idle(); rd0(5'd7); step();
    chk("bypass0_next", ib.rd_data[31:0], 128'h55);

    // All four ports read one register, then hold.
    idle(); wr(5'd2, 4'hF, 32'h1234); step();
    idle(); rd_en = 4'b1111; rd_addr = {4{5'd2}}; step();
    chk("multi_data", ia.rd_data, {4{32'h1234}});
    chk("multi_valid", {124'd0, ia.rd_valid}, 128'hF);
    idle(); step();
    chk("hold_data", ia.rd_data, {4{32'h1234}});
    chk("hold_valid", {124'd0, ia.rd_valid}, 128'd0);

    // Asynchronous reset between edges while a write targets r9.
    idle(); wr(5'd9, 4'hF, 32'h77); step();
    idle(); rd0(5'd9); step();
    chk("r9_pre", ia.rd_data[31:0], 128'h77);
    wr(5'd9, 4'hF, 32'hCAFE); rd0(5'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_data", ia.rd_data, 128'd0);
    chk("async_valid", {124'd0, ia.rd_valid}, 128'd0);
    step();
    chk("async_hold", ia.rd_data, 128'd0);
    rst_n = 1'b1;
    idle(); rd0(5'd9); step();
    chk("r9_cleared_a", ia.rd_data[31:0], 128'd0);
    chk("r9_cleared_b", ib.rd_data[31:0], 128'd0);

    idle(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
